// File: rtl/trace_buffer_drain.sv
// Read-side master for the trace buffer: requests one element at a time and
// serializes it MSB-first into OUT_WIDTH-bit beats on a valid/ready stream.
module trace_buffer_drain #(
    parameter int TRACE_WIDTH = 64,
    parameter int OUT_WIDTH   = 8,
    parameter int REQ_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   data_present,
    input  logic                   data_valid,
    input  logic [TRACE_WIDTH-1:0] trace_element_in,
    output logic                   data_request,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [31:0]            drained_count
);

    localparam int BEATS  = (TRACE_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int EXT_W  = BEATS * OUT_WIDTH;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TMO_W  = $clog2(REQ_TIMEOUT + 1);
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BEATS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(REQ_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_VALID, SEND} state_t;

    state_t              state, state_n;
    logic [BIDX_W-1:0]   beat_idx, beat_idx_n;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_n;
    logic [EXT_W-1:0]    shreg, shreg_n;
    logic [EXT_W-1:0]    ext_elem;
    logic                data_request_n, out_valid_n, out_last_n, busy_n, timeout_err_n;
    logic [OUT_WIDTH-1:0] out_data_n;
    logic [31:0]         drained_count_n;

    assign ext_elem = EXT_W'(trace_element_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat_idx      <= '0;
            tmo_cnt       <= '0;
            shreg         <= '0;
            data_request  <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            drained_count <= '0;
        end else begin
            state         <= state_n;
            beat_idx      <= beat_idx_n;
            tmo_cnt       <= tmo_cnt_n;
            shreg         <= shreg_n;
            data_request  <= data_request_n;
            out_valid     <= out_valid_n;
            out_data      <= out_data_n;
            out_last      <= out_last_n;
            busy          <= busy_n;
            timeout_err   <= timeout_err_n;
            drained_count <= drained_count_n;
        end
    end

    always_comb begin
        state_n         = state;
        beat_idx_n      = beat_idx;
        tmo_cnt_n       = tmo_cnt;
        shreg_n         = shreg;
        data_request_n  = 1'b0;
        out_valid_n     = out_valid;
        out_data_n      = out_data;
        out_last_n      = out_last;
        timeout_err_n   = timeout_err;
        drained_count_n = drained_count;

        case (state)
            IDLE: begin
                if (enable && data_present) begin
                    state_n        = REQUEST;
                    data_request_n = 1'b1;
                end
            end
            REQUEST: begin
                state_n   = WAIT_VALID;
                tmo_cnt_n = '0;
            end
            WAIT_VALID: begin
                // A response in the final wait cycle still wins over the timeout.
                if (data_valid) begin
                    out_data_n  = ext_elem[EXT_W-1 -: OUT_WIDTH];
                    shreg_n     = ext_elem << OUT_WIDTH;
                    beat_idx_n  = '0;
                    out_valid_n = 1'b1;
                    out_last_n  = (BEATS == 1);
                    state_n     = SEND;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_err_n = 1'b1;
                    state_n       = IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (beat_idx == LAST_IDX) begin
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                        out_data_n  = '0;
                        state_n     = IDLE;
                        if (drained_count != '1)
                            drained_count_n = drained_count + 32'd1;
                    end else begin
                        out_data_n = shreg[EXT_W-1 -: OUT_WIDTH];
                        shreg_n    = shreg << OUT_WIDTH;
                        beat_idx_n = beat_idx + 1'b1;
                        out_last_n = ((beat_idx + 1'b1) == LAST_IDX);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_trace_buffer_drain.sv
// Directed bench: a queue-based buffer model and beat scoreboard checked every
// cycle for the 64/8 instance, plus literal checks for a 12/8 instance.
module tb_trace_buffer_drain;

    localparam int TMO = 16;
    localparam int NB  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, data_present, data_valid, out_ready;
    logic [63:0] trace_element_in;
    logic        data_request, out_valid, out_last, busy, timeout_err;
    logic [7:0]  out_data;
    logic [31:0] drained_count;

    logic        d12_present, d12_dv;
    logic [11:0] d12_elem;
    logic        d12_req, d12_valid, d12_last, d12_busy, d12_err;
    logic [7:0]  d12_data;
    logic [31:0] d12_drained;

    trace_buffer_drain #(.TRACE_WIDTH(64), .OUT_WIDTH(8), .REQ_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_present(data_present),
        .data_valid(data_valid), .trace_element_in(trace_element_in),
        .data_request(data_request), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy),
        .timeout_err(timeout_err), .drained_count(drained_count));

    trace_buffer_drain #(.TRACE_WIDTH(12), .OUT_WIDTH(8), .REQ_TIMEOUT(TMO)) dut12 (
        .clk(clk), .rst_n(rst_n), .enable(1'b1), .data_present(d12_present),
        .data_valid(d12_dv), .trace_element_in(d12_elem),
        .data_request(d12_req), .out_valid(d12_valid), .out_ready(1'b1),
        .out_data(d12_data), .out_last(d12_last), .busy(d12_busy),
        .timeout_err(d12_err), .drained_count(d12_drained));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // buffer model
    logic [63:0] buf_q[$];
    bit          responsive = 1'b1;
    bit          stray = 1'b0;
    int          resp_cnt = 0;

    // scoreboard / reference model
    typedef struct { logic [7:0] d; logic l; } beat_t;
    beat_t      exp_q[$];
    bit         pending = 1'b0;
    int         age = 0;
    bit         exp_err = 1'b0;
    int         exp_drained = 0;
    int         hs_count = 0;
    logic [7:0] hs_log[$];
    int         req_count = 0;
    int         cyc = 0, req_cyc = 0, err_cyc = 0, rise_cyc = 0;
    bit         err_seen = 1'b0, prev_busy = 1'b0, prev_valid = 1'b0;

    initial begin
        data_valid = 1'b0;
        data_present = 1'b0;
        trace_element_in = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) resp_cnt = 0;
            else if (data_request && responsive) resp_cnt = 2;
            @(posedge clk);
            #1;
            data_valid = 1'b0;
            if (stray) begin
                data_valid = 1'b1;
                trace_element_in = 64'hDEADBEEF0BADF00D;
                stray = 1'b0;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0 && buf_q.size() != 0) begin
                    data_valid = 1'b1;
                    trace_element_in = buf_q.pop_front();
                end
            end
            data_present = (buf_q.size() != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                pending = 1'b0;
                exp_err = 1'b0;
                exp_drained = 0;
                chk("rst_data_request", data_request, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_busy", busy, 0);
                chk("rst_timeout_err", timeout_err, 0);
                chk("rst_drained", drained_count, 0);
            end else begin
                if (pending) begin
                    age++;
                    if (age > TMO) begin
                        pending = 1'b0;
                        exp_err = 1'b1;
                    end
                end
                chk("timeout_err", timeout_err, exp_err);
                if (timeout_err && !err_seen) begin
                    err_seen = 1'b1;
                    err_cyc = cyc;
                end
                chk("drained_count", drained_count, exp_drained);
                if (data_request) begin
                    req_count++;
                    req_cyc = cyc;
                    chk("req_legal", (!pending && exp_q.size() == 0 && buf_q.size() != 0), 1);
                    chk("req_after_idle", prev_busy, 0);
                    pending = 1'b1;
                    age = 0;
                end
                chk("busy", busy, (pending || exp_q.size() != 0));
                chk("out_valid", out_valid, (exp_q.size() != 0));
                if (out_valid && !prev_valid) rise_cyc = cyc;
                if (out_valid && exp_q.size() != 0) begin
                    chk("out_data", out_data, exp_q[0].d);
                    chk("out_last", out_last, exp_q[0].l);
                    if (out_ready) begin
                        hs_log.push_back(out_data);
                        hs_count++;
                        if (exp_q[0].l) exp_drained++;
                        void'(exp_q.pop_front());
                    end
                end
                if (data_valid && pending) begin
                    pending = 1'b0;
                    for (int k = 0; k < NB; k++) begin
                        beat_t b;
                        b.d = 8'((trace_element_in >> ((NB - 1 - k) * 8)) & 64'hFF);
                        b.l = (k == NB - 1);
                        exp_q.push_back(b);
                    end
                end
            end
            prev_busy = busy;
            prev_valid = out_valid;
        end
    end

    task automatic wait_drain(input int budget);
        int  n = 0;
        bit  done = 1'b0;
        while (n < budget && !done) begin
            @(negedge clk);
            done = (buf_q.size() == 0 && resp_cnt == 0 && !pending && exp_q.size() == 0 && !busy);
            n++;
        end
        chk("drain_within_bound", done, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (n < 200 && hs_count < target) begin
            @(posedge clk);
            n++;
        end
        chk("hs_within_bound", (hs_count >= target), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int r0, n, base;
        bit seen;
        rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1;
        d12_present = 1'b0; d12_dv = 1'b0; d12_elem = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("d12_rst_valid", d12_valid, 0);
        chk("d12_rst_drained", d12_drained, 0);
        @(posedge clk);
        #1 rst_n = 1'b1; enable = 1'b1;

        // single element, prompt buffer
        buf_q.push_back(64'h0123456789ABCDEF);
        wait_drain(100);
        chk("t1_reqs", req_count, 1);
        chk("t1_beats", hs_log.size(), 8);
        chk("t1_beat0", hs_log[0], 8'h01);
        chk("t1_beat3", hs_log[3], 8'h67);
        chk("t1_beat7", hs_log[7], 8'hEF);
        chk("t1_drained", drained_count, 1);
        chk("t1_latency", rise_cyc - req_cyc, 3);

        // three queued elements
        hs_log.delete();
        req_count = 0;
        buf_q.push_back(64'h1122334455667788);
        buf_q.push_back(64'h99AABBCCDDEEFF00);
        buf_q.push_back(64'hFEDCBA9876543210);
        wait_drain(300);
        repeat (10) @(posedge clk);
        chk("t2_reqs", req_count, 3);
        chk("t2_beats", hs_log.size(), 24);
        chk("t2_beat8", hs_log[8], 8'h99);
        chk("t2_beat23", hs_log[23], 8'h10);
        chk("t2_drained", drained_count, 4);

        // downstream stall on beat 3
        hs_log.delete();
        base = hs_count;
        buf_q.push_back(64'h0123456789ABCDEF);
        wait_hs(base + 3);
        #1 out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t3_stall_data", out_data, 8'h67);
            chk("t3_stall_last", out_last, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain(100);
        chk("t3_beats", hs_log.size(), 8);
        chk("t3_beat3", hs_log[3], 8'h67);
        chk("t3_beat4", hs_log[4], 8'h89);

        // stray data_valid while idle is ignored
        stray = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_drained", drained_count, 5);

        // unanswered request times out, later element still drains
        hs_log.delete();
        responsive = 1'b0;
        r0 = req_count;
        buf_q.push_back(64'hCAFEF00D12345678);
        n = 0;
        while (n < 20 && req_count == r0) begin @(posedge clk); n++; end
        #1 enable = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin @(negedge clk); seen = err_seen; n++; end
        chk("t4_err_seen", seen, 1);
        chk("t4_err_latency", err_cyc - req_cyc, TMO + 1);
        @(negedge clk);
        chk("t4_idle", busy, 0);
        @(posedge clk);
        #1 responsive = 1'b1; enable = 1'b1;
        wait_drain(100);
        chk("t4_err_sticky", timeout_err, 1);
        chk("t4_drained", drained_count, 6);
        chk("t4_beat0", hs_log[0], 8'hCA);

        // reset in the middle of an element
        hs_log.delete();
        base = hs_count;
        buf_q.push_back(64'h0123456789ABCDEF);
        wait_hs(base + 4);
        #1 rst_n = 1'b0;
        buf_q.push_back(64'h0123456789ABCDEF);
        @(negedge clk);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_last", out_last, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_drain(100);
        chk("t5_beats", hs_log.size(), 12);
        chk("t5_restart_beat0", hs_log[4], 8'h01);
        chk("t5_last_beat", hs_log[11], 8'hEF);
        chk("t5_drained", drained_count, 1);
        chk("t5_err_cleared", timeout_err, 0);

        // 12-bit element over 8-bit beats
        d12_present = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 10 && !seen) begin @(negedge clk); seen = d12_req; n++; end
        chk("d12_req", seen, 1);
        @(posedge clk); #1 d12_present = 1'b0;
        @(posedge clk); #1 d12_dv = 1'b1; d12_elem = 12'hABC;
        @(posedge clk); #1 d12_dv = 1'b0;
        @(negedge clk);
        chk("d12_b0_valid", d12_valid, 1);
        chk("d12_b0_data", d12_data, 8'h0A);
        chk("d12_b0_last", d12_last, 0);
        @(negedge clk);
        chk("d12_b1_valid", d12_valid, 1);
        chk("d12_b1_data", d12_data, 8'hBC);
        chk("d12_b1_last", d12_last, 1);
        @(negedge clk);
        chk("d12_done_valid", d12_valid, 0);
        chk("d12_drained", d12_drained, 1);
        chk("d12_busy", d12_busy, 0);
        chk("d12_err", d12_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
